// File: rtl/ram_loader.sv
// Boot/debug loader: parses framed byte streams (HEADER, ADDR, COUNT, words, CHK)
// from a valid/ready source and writes the assembled 16-bit words into the data RAM.
module ram_loader #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         ADDR_BITS      = 8,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        write_enable,
    output logic        read_enable,
    output logic [15:0] address,
    output logic [15:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_COUNT, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHK
    } state_t;

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] index;
    logic [8:0]           remaining;
    logic [7:0]           chk_acc;
    logic [TW-1:0]        timer;
    logic                 xfer;
    logic                 timeout_hit;

    assign xfer        = in_valid & in_ready;
    // The timer only runs while waiting on the source; WRITE never waits for a byte.
    assign timeout_hit = (state != S_IDLE) && (state != S_WRITE) && !xfer &&
                         (timer == TW'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: combinational blocks assign a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (xfer && in_data == HEADER) state_next = S_ADDR;
                S_ADDR:    if (xfer) state_next = S_COUNT;
                S_COUNT:   if (xfer) state_next = S_DATA_HI;
                S_DATA_HI: if (xfer) state_next = S_DATA_LO;
                S_DATA_LO: if (xfer) state_next = S_WRITE;
                S_WRITE:   state_next = (remaining == 9'd1) ? S_CHK : S_DATA_HI;
                S_CHK:     if (xfer) state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state != S_WRITE);
        write_enable = (state == S_WRITE);
        busy         = (state != S_IDLE);
    end

    assign read_enable = 1'b0;
    assign address     = 16'(index);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == S_IDLE || state == S_WRITE || xfer) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            index      <= '0;
            remaining  <= '0;
            chk_acc    <= '0;
            write_data <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= 2'b00;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (timeout_hit) begin
                error      <= 1'b1;
                error_code <= 2'b10;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (xfer && in_data == HEADER) begin
                            error_code <= 2'b00;
                            chk_acc    <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (xfer) begin
                            index   <= ADDR_BITS'(in_data);
                            chk_acc <= chk_acc ^ in_data;
                        end
                    end
                    S_COUNT: begin
                        if (xfer) begin
                            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                            chk_acc   <= chk_acc ^ in_data;
                        end
                    end
                    S_DATA_HI: begin
                        if (xfer) begin
                            write_data[15:8] <= in_data;
                            chk_acc          <= chk_acc ^ in_data;
                        end
                    end
                    S_DATA_LO: begin
                        if (xfer) begin
                            write_data[7:0] <= in_data;
                            chk_acc         <= chk_acc ^ in_data;
                        end
                    end
                    S_WRITE: begin
                        index     <= index + 1'b1;
                        remaining <= remaining - 9'd1;
                    end
                    S_CHK: begin
                        if (xfer) begin
                            if (in_data == chk_acc) begin
                                done <= 1'b1;
                            end else begin
                                error      <= 1'b1;
                                error_code <= 2'b01;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Randomized scoreboard bench for ram_loader: a frame-level model predicts RAM writes
// and frame outcomes; an independent monitor compares them as the DUT produces them.
module tb_ram_loader;

    localparam int T_CYCLES = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] address;
    logic [15:0] write_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;

    ram_loader #(
        .HEADER(8'hA5), .ADDR_BITS(8), .TIMEOUT_CYCLES(T_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .write_enable(write_enable), .read_enable(read_enable),
        .address(address), .write_data(write_data), .busy(busy), .done(done),
        .error(error), .error_code(error_code)
    );

    always #5 clock = ~clock;

    int          pass_cnt  = 0;
    int          check_cnt = 0;
    int          stall_acc = 0;
    logic [31:0] wr_q[$];        // expected {address, write_data}
    logic [1:0]  ev_q[$];        // expected outcome: 0 done, 1 checksum, 2 timeout
    logic [15:0] frame_words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or ends a frame.
    initial begin
        logic [31:0] e;
        logic [1:0]  ev;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (write_enable) begin
                    if (wr_q.size() > 0) e = wr_q.pop_front();
                    else                 e = 'x;
                    check("write", {address, write_data}, e);
                end
                if (done || error) begin
                    if (ev_q.size() > 0) ev = ev_q.pop_front();
                    else                 ev = 2'b11;
                    check("outcome", {28'd0, done, error, error_code},
                          {28'd0, ev == 2'b00, ev != 2'b00, ev});
                    check("busy_at_end", busy, 1'b0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int w;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clock);
        end
        in_data  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 8) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) check("in_ready_stuck", in_ready, 1'b1);
        stall_acc += w;
        @(negedge clock);
    endtask

    task automatic fill_words(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
    endtask

    // Reference model: expected writes and checksum follow directly from the frame rules.
    task automatic send_frame(input logic [7:0] addr, input logic [7:0] cnt,
                              input logic bad_chk, input int gap_max);
        logic [7:0] chk;
        logic [7:0] a_i;
        int         n;
        n   = (cnt == 8'd0) ? 256 : int'(cnt);
        chk = addr ^ cnt;
        for (int i = 0; i < n; i++) begin
            a_i = addr + 8'(i);
            wr_q.push_back({8'h00, a_i, frame_words[i]});
            chk = chk ^ frame_words[i][15:8] ^ frame_words[i][7:0];
        end
        ev_q.push_back(bad_chk ? 2'b01 : 2'b00);
        if (bad_chk) chk = chk ^ 8'($urandom_range(1, 255));
        send_byte(8'hA5, gap_max);
        check("busy_after_header", busy, 1'b1);
        stall_acc = 0;
        send_byte(addr, gap_max);
        send_byte(cnt, gap_max);
        for (int i = 0; i < n; i++) begin
            send_byte(frame_words[i][15:8], gap_max);
            send_byte(frame_words[i][7:0], gap_max);
        end
        send_byte(chk, gap_max);
        in_valid = 1'b0;
        if (gap_max == 0) check("write_stalls", 32'(stall_acc), 32'(n));
        repeat (2) @(negedge clock);
        if (bad_chk) check("error_code_held", error_code, 2'b01);
    endtask

    initial begin
        int         n;
        logic [7:0] g;

        repeat (3) @(negedge clock);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_outputs", {write_enable, read_enable, busy, done, error, error_code}, 7'd0);
        check("rst_address", address, 16'h0000);
        check("rst_write_data", write_data, 16'h0000);
        reset = 1'b1;
        @(negedge clock);

        // Directed frame with known words, then the same frame with a bad checksum.
        frame_words = '{16'h1234, 16'hABCD};
        send_frame(8'h10, 8'h02, 1'b0, 0);
        send_frame(8'h10, 8'h02, 1'b1, 0);

        // Index wraps from 0xFF to 0x00.
        frame_words = '{16'h0001, 16'h0002};
        send_frame(8'hFF, 8'h02, 1'b0, 0);

        // Noise bytes before the header are dropped without starting a frame.
        send_byte(8'h00, 0);
        send_byte(8'h55, 0);
        in_valid = 1'b0;
        @(negedge clock);
        check("busy_idle_noise", busy, 1'b0);
        fill_words(1);
        send_frame(8'h33, 8'h01, 1'b0, 0);

        // Inter-byte timeout after DATA_HI: no write, error code 10.
        ev_q.push_back(2'b10);
        send_byte(8'hA5, 0);
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        in_valid = 1'b0;
        n = 0;
        while (!error && n < 3 * T_CYCLES) begin
            @(negedge clock);
            n++;
        end
        check("timeout_latency", 32'(n), 32'(T_CYCLES));
        repeat (3) @(negedge clock);
        check("timeout_code_held", error_code, 2'b10);

        // Reset asserted mid-frame after DATA_HI.
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        in_valid = 1'b0;
        check("busy_mid_frame", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_outputs", {write_enable, busy, done, error, error_code}, 6'd0);
        check("midrst_address", address, 16'h0000);
        check("midrst_write_data", write_data, 16'h0000);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        frame_words = '{16'h1234, 16'hABCD};
        send_frame(8'h10, 8'h02, 1'b0, 0);

        // Full 256-word frame (COUNT byte 0).
        fill_words(256);
        send_frame(8'($urandom), 8'h00, 1'b0, 0);

        // Randomized frames, noise, gaps and corrupted checksums.
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 0);
                in_valid = 1'b0;
                @(negedge clock);
                check("busy_idle_rand_noise", busy, 1'b0);
            end
            n = $urandom_range(1, 6);
            fill_words(n);
            send_frame(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom), 8'(n),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0) ? 0 : 4);
        end

        repeat (5) @(negedge clock);
        check("writes_outstanding", 32'(wr_q.size()), 32'd0);
        check("outcomes_outstanding", 32'(ev_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
